// File: rtl/pif_regbank.sv
// pif_regbank: ID ROM, scratch RAM, control and optional counter behind the PIF bridge.
// Optional free-running counter: define PIF_REGBANK_CNT_EN.
module pif_regbank #(
  parameter int          ADDR_W  = 6,
  parameter int          SUBA_W  = 3,
  parameter int          DATA_W  = 6,
  parameter logic [31:0] ID_WORD = 32'h50494601
) (
  input  logic              xclk,
  input  logic              rst,
  input  logic              XI_PWr,
  input  logic [ADDR_W-1:0] XI_PRWA,
  input  logic [DATA_W-1:0] XI_PD,
  input  logic              XI_PRdFinished,
  input  logic [SUBA_W-1:0] XI_PRdSubA,
  output logic [7:0]        XO,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] A_ID  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_SCR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CTL = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CNT = ADDR_W'(3);

  logic [ADDR_W-1:0] r_prev_addr;
  logic [SUBA_W-1:0] r_wr_ptr;
  logic [7:0]        r_scratch [8];
  logic [DATA_W-1:0] r_ctrl;
  logic              r_wr_err;
  logic [7:0]        r_xo;

  logic              w_addr_chg;
  logic              w_is_id;
  logic              w_is_scr;
  logic              w_is_ctl;
  logic              w_is_cnt;
  logic              w_wr_bad;
  logic [2:0]        w_widx;
  logic [2:0]        w_ridx;
  logic [1:0]        w_idb;
  logic [SUBA_W-1:0] w_ptr_nxt;
  logic [7:0]        w_rd;
  logic [7:0]        w_cnt_rd;

  assign w_addr_chg = (XI_PRWA != r_prev_addr);
  assign w_is_id    = (XI_PRWA == A_ID);
  assign w_is_scr   = (XI_PRWA == A_SCR);
  assign w_is_ctl   = (XI_PRWA == A_CTL);
  assign w_is_cnt   = (XI_PRWA == A_CNT);
  assign w_wr_bad   = XI_PWr & ~(w_is_scr | w_is_ctl);
  assign w_widx     = w_addr_chg ? 3'd0 : 3'(r_wr_ptr);
  assign w_ridx     = 3'(XI_PRdSubA);
  assign w_idb      = 2'(XI_PRdSubA);

  // A write on the address-change cycle lands at index 0 and leaves ptr at 1
  always_comb begin
    w_ptr_nxt = r_wr_ptr;
    if (w_addr_chg)
      w_ptr_nxt = XI_PWr ? SUBA_W'(1) : '0;
    else if (XI_PWr)
      w_ptr_nxt = r_wr_ptr + SUBA_W'(1);
  end

`ifdef PIF_REGBANK_CNT_EN
  logic [15:0] r_cnt;
  logic [15:0] r_snap;
  logic        w_snap_ld;

  assign w_snap_ld = w_is_cnt &
                     (w_addr_chg |
                      (XI_PRdFinished & (XI_PRdSubA == SUBA_W'(1))));

  always_ff @(posedge xclk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
      if (w_snap_ld)
        r_snap <= r_cnt;
    end
  end

  always_comb begin
    w_cnt_rd = 8'h00;
    if (XI_PRdSubA == SUBA_W'(0))
      w_cnt_rd = r_snap[7:0];
    else if (XI_PRdSubA == SUBA_W'(1))
      w_cnt_rd = r_snap[15:8];
  end
`else
  logic w_unused;
  assign w_unused = XI_PRdFinished;
  assign w_cnt_rd = 8'h00;
`endif

  always_comb begin
    w_rd = 8'hFF;
    unique case (1'b1)
      w_is_id:  w_rd = 8'(ID_WORD >> {w_idb, 3'b000});
      w_is_scr: w_rd = r_scratch[w_ridx];
      w_is_ctl: w_rd = 8'(r_ctrl);
      w_is_cnt: w_rd = w_cnt_rd;
      default:  w_rd = 8'hFF;
    endcase
  end

  always_ff @(posedge xclk) begin
    if (rst) begin
      r_prev_addr <= '0;
      r_wr_ptr    <= '0;
      r_ctrl      <= '0;
      r_wr_err    <= 1'b0;
      r_xo        <= 8'h00;
      for (int i = 0; i < 8; i++)
        r_scratch[i] <= 8'h00;
    end else begin
      r_prev_addr <= XI_PRWA;
      r_wr_ptr    <= w_ptr_nxt;
      r_wr_err    <= w_wr_bad;
      r_xo        <= w_rd;
      if (XI_PWr && w_is_scr)
        r_scratch[w_widx] <= 8'(XI_PD);
      if (XI_PWr && w_is_ctl)
        r_ctrl <= XI_PD;
    end
  end

  assign XO     = r_xo;
  assign ctrl_o = r_ctrl;
  assign wr_err = r_wr_err;

endmodule
